// File: rtl/tick_divider_pkg.sv
// rtl/tick_divider_pkg.sv - default constants and counter width helper for tick_divider
package tick_divider_pkg;

  localparam int DEF_PRESCALE  = 500000;
  localparam int DEF_STAGE_DIV = 10;
  localparam int DEF_N_STAGES  = 2;
  localparam int CLK_HZ        = 50_000_000;

  // A modulus of 1 or 2 still needs one register bit.
  function automatic int cnt_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_divider_if.sv
// rtl/tick_divider_if.sv - control inputs and tick/square outputs of tick_divider
interface tick_divider_if
  import tick_divider_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES
);

  logic              enable;
  logic              clear;
  logic [N_STAGES:0] tick;
  logic [N_STAGES:0] sq;

  modport master (output enable, output clear, input tick, input sq);
  modport slave  (input enable, input clear, output tick, output sq);

endinterface

// File: rtl/tick_divider_mod_counter.sv
// rtl/tick_divider_mod_counter.sv - modulo-MOD counter with synchronous restart and terminal flag
module mod_counter
  import tick_divider_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic                   CLK_50MHz,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   inc,
  output logic [cnt_w(MOD)-1:0]  count,
  output logic                   at_max
);

  localparam int           W   = cnt_w(MOD);
  localparam logic [W-1:0] MAX = W'(MOD - 1);

  assign at_max = (count == MAX);

  always_ff @(posedge CLK_50MHz) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - synchronous prescaler plus cascaded decade stages emitting clock-enable ticks
// Square-wave outputs are built only when TICK_DIVIDER_SQUARE_EN is defined.
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int STAGE_DIV = DEF_STAGE_DIV,
  parameter int N_STAGES  = DEF_N_STAGES
) (
  input  logic          CLK_50MHz,
  input  logic          reset,
  tick_divider_if.slave bus
);

  localparam int PW = cnt_w(PRESCALE);
  localparam int SW = cnt_w(STAGE_DIV);

  if (PRESCALE < 2 || STAGE_DIV < 2 || N_STAGES < 0) begin : g_param_check
    $error("tick_divider: PRESCALE and STAGE_DIV must be >= 2, N_STAGES >= 0");
  end

  logic [N_STAGES:0] wrap;
  logic [N_STAGES:0] tick_q;
  logic [PW-1:0]     pre;
  logic              pre_max;

  mod_counter #(.MOD(PRESCALE)) u_pre (
    .CLK_50MHz (CLK_50MHz),
    .reset     (reset),
    .clear     (bus.clear),
    .inc       (bus.enable),
    .count     (pre),
    .at_max    (pre_max)
  );

  assign wrap[0] = bus.enable & pre_max;

`ifdef TICK_DIVIDER_SQUARE_EN
  logic [N_STAGES:0] half;
  logic [N_STAGES:0] sq_q;
  assign half[0] = (pre >= PW'(PRESCALE / 2));
`endif

  // Each stage advances only when every faster stage wraps in the same cycle.
  for (genvar j = 1; j <= N_STAGES; j++) begin : g_stage
    logic [SW-1:0] cnt;
    logic          cnt_max;

    mod_counter #(.MOD(STAGE_DIV)) u_cnt (
      .CLK_50MHz (CLK_50MHz),
      .reset     (reset),
      .clear     (bus.clear),
      .inc       (wrap[j-1]),
      .count     (cnt),
      .at_max    (cnt_max)
    );

    assign wrap[j] = wrap[j-1] & cnt_max;

`ifdef TICK_DIVIDER_SQUARE_EN
    assign half[j] = (cnt >= SW'(STAGE_DIV / 2));
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt;
`endif
  end

  always_ff @(posedge CLK_50MHz) begin
    if (reset || bus.clear) begin
      tick_q <= '0;
    end else begin
      tick_q <= wrap;
    end
  end

  assign bus.tick = tick_q;

`ifdef TICK_DIVIDER_SQUARE_EN
  if ((PRESCALE % 2) != 0 || (STAGE_DIV % 2) != 0) begin : g_even_check
    $error("tick_divider: square outputs need even PRESCALE and STAGE_DIV");
  end

  always_ff @(posedge CLK_50MHz) begin
    if (reset || bus.clear) begin
      sq_q <= '0;
    end else begin
      sq_q <= half;
    end
  end

  assign bus.sq = sq_q;
`else
  logic unused_pre;
  assign unused_pre = ^pre;
  assign bus.sq     = '0;
`endif

endmodule
